// File: rtl/demod_mult_sched_pkg.sv
// Shared definitions for the lock-in demodulator multiplier scheduler:
// FSM state encoding, result-tag encoding and datapath widths.
package lockin_pkg;

  localparam int SAMPLE_W = 16;
  localparam int PROD_W   = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE_SIN = 3'd1,
    ST_ISSUE_COS = 3'd2,
    ST_WAIT      = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  // Marks which product is currently on the multiplier output.
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_SIN  = 2'd1,
    TAG_COS  = 2'd2
  } tag_t;

endpackage

// File: rtl/demod_mult_sched_if.sv
// Bus to the shared signed 16x16 multiplier.
// Handshake: there is no valid/ready pair. Operands on m_a/m_b are consumed
// every cycle; m_p carries the product of the operands presented MULT_LAT
// cycles earlier. The scheduler knows which product is on m_p from its own
// tag pipe, so the multiplier side never stalls and never signals.
interface demod_mult_sched_if;
  import lockin_pkg::*;

  logic signed [SAMPLE_W-1:0] m_a;
  logic signed [SAMPLE_W-1:0] m_b;
  logic signed [PROD_W-1:0]   m_p;

  // Scheduler side: drives operands, receives product.
  modport master (output m_a, output m_b, input m_p);
  // Multiplier side: receives operands, drives product.
  modport slave  (input m_a, input m_b, output m_p);
endinterface

// File: rtl/demod_mult_sched_tag_delay.sv
// DEPTH-stage shift register of result tags, aligned with the multiplier
// pipeline so the output tag describes the product currently on m_p.
module tag_delay
  import lockin_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic i_clr,
  input  tag_t i_tag,
  output tag_t o_tag
);

  tag_t r_pipe [DEPTH];

  // Shift tags one stage per cycle; clear drops every in-flight tag.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= TAG_NONE;
    end else begin
      r_pipe[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_tag = r_pipe[DEPTH-1];

endmodule

// File: rtl/demod_mult_sched.sv
// Time-multiplexes one shared multiplier between the sin*adc and cos*adc
// demodulation products. Per sample: latch, issue sin pair, issue cos pair,
// wait for the cos product, then present both products with modvalid.
module demod_mult_sched
  import lockin_pkg::*;
#(
  parameter int MULT_LAT = 2
) (
  input  logic                       CLK36,
  input  logic                       rst,
  input  logic                       newdata,
  input  logic signed [SAMPLE_W-1:0] adcdata,
  input  logic signed [SAMPLE_W-1:0] sin,
  input  logic signed [SAMPLE_W-1:0] cos,
  demod_mult_sched_if.master         mult,
  output logic signed [PROD_W-1:0]   sinmod,
  output logic signed [PROD_W-1:0]   cosmod,
  output logic                       modvalid,
  output logic                       busy,
  output logic                       overrun,
  input  logic                       clr_overrun,
  output state_t                     o_dbg_state
);

  state_t                     r_state;
  logic signed [SAMPLE_W-1:0] r_adc;
  logic signed [SAMPLE_W-1:0] r_cos;
  logic signed [PROD_W-1:0]   r_sin_hold;
  logic                       w_in_flight;
  tag_t                       w_tag_in;
  tag_t                       w_tag_out;

  assign w_in_flight = (r_state == ST_ISSUE_SIN) || (r_state == ST_ISSUE_COS) ||
                       (r_state == ST_WAIT);
  assign o_dbg_state = r_state;

  // Tag the operand pair being issued this cycle.
  always_comb begin
    w_tag_in = TAG_NONE;
    if (r_state == ST_ISSUE_SIN)      w_tag_in = TAG_SIN;
    else if (r_state == ST_ISSUE_COS) w_tag_in = TAG_COS;
  end

  tag_delay #(.DEPTH(MULT_LAT)) u_tag_delay (
    .clk   (CLK36),
    .i_clr (rst),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );

  // Scheduler FSM with registered operand, result and status outputs.
  // The sine operand is driven onto m_a on the latch edge, so only adc and
  // cos need holding registers. The cos product arrives on the same edge
  // that enters DONE, so it is written straight into cosmod.
  always_ff @(posedge CLK36) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_adc      <= '0;
      r_cos      <= '0;
      r_sin_hold <= '0;
      mult.m_a   <= '0;
      mult.m_b   <= '0;
      sinmod     <= '0;
      cosmod     <= '0;
      modvalid   <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      modvalid <= 1'b0;
      if (w_tag_out == TAG_SIN) r_sin_hold <= mult.m_p;

      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (newdata) begin
            r_adc    <= adcdata;
            r_cos    <= cos;
            mult.m_a <= sin;
            mult.m_b <= adcdata;
            busy     <= 1'b1;
            r_state  <= ST_ISSUE_SIN;
          end else begin
            r_state  <= ST_IDLE;
          end
        end
        ST_ISSUE_SIN: begin
          mult.m_a <= r_cos;
          mult.m_b <= r_adc;
          r_state  <= ST_ISSUE_COS;
        end
        ST_ISSUE_COS: begin
          mult.m_a <= '0;
          mult.m_b <= '0;
          r_state  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_tag_out == TAG_COS) begin
            sinmod   <= r_sin_hold;
            cosmod   <= mult.m_p;
            modvalid <= 1'b1;
            busy     <= 1'b0;
            r_state  <= ST_DONE;
          end
        end
        default: begin
          mult.m_a <= '0;
          mult.m_b <= '0;
          busy     <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase

      // A sample arriving mid-computation is dropped; setting beats clearing.
      if (newdata && w_in_flight) overrun <= 1'b1;
      else if (clr_overrun)       overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_demod_mult_sched.sv
// Bench for demod_mult_sched: three instances (MULT_LAT 1, 2, 4) each with
// a behavioural pipelined multiplier. Directed steps exercise the MULT_LAT=2
// instance; a random sweep exercises all three. A scoreboard queue per
// instance holds {expected cycle, sinmod, cosmod} pushed when a sample is
// driven and popped when modvalid is seen.
module tb_demod_mult_sched;
  import lockin_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT wiring ----------------
  logic              nd     [3];
  logic signed [15:0] adc_in [3];
  logic signed [15:0] sin_in [3];
  logic signed [15:0] cos_in [3];
  logic              clr_ov [3];
  logic signed [15:0] w_ma   [3];
  logic signed [15:0] w_mb   [3];
  logic signed [31:0] w_sinmod [3];
  logic signed [31:0] w_cosmod [3];
  logic              w_mv   [3];
  logic              w_busy [3];
  logic              w_ovr  [3];
  state_t            w_state [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    demod_mult_sched_if mif();
    logic signed [31:0] r_pp [L];

    // Behavioural multiplier with L register stages.
    always @(posedge clk) begin
      r_pp[0] <= mif.m_a * mif.m_b;
      for (int i = 1; i < L; i++) r_pp[i] <= r_pp[i-1];
    end
    assign mif.m_p = r_pp[L-1];

    demod_mult_sched #(.MULT_LAT(L)) u_dut (
      .CLK36       (clk),
      .rst         (rst),
      .newdata     (nd[g]),
      .adcdata     (adc_in[g]),
      .sin         (sin_in[g]),
      .cos         (cos_in[g]),
      .mult        (mif),
      .sinmod      (w_sinmod[g]),
      .cosmod      (w_cosmod[g]),
      .modvalid    (w_mv[g]),
      .busy        (w_busy[g]),
      .overrun     (w_ovr[g]),
      .clr_overrun (clr_ov[g]),
      .o_dbg_state (w_state[g])
    );
    assign w_ma[g] = mif.m_a;
    assign w_mb[g] = mif.m_b;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [95:0] exp_q0 [$];
  logic [95:0] exp_q1 [$];
  logic [95:0] exp_q2 [$];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic push_exp(input int k, input logic [95:0] v);
    case (k)
      0:       exp_q0.push_back(v);
      1:       exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endtask

  task automatic pop_exp(input int k, output bit ok, output logic [95:0] v);
    ok = 1'b0;
    v  = '0;
    case (k)
      0:       if (exp_q0.size() > 0) begin ok = 1'b1; v = exp_q0.pop_front(); end
      1:       if (exp_q1.size() > 0) begin ok = 1'b1; v = exp_q1.pop_front(); end
      default: if (exp_q2.size() > 0) begin ok = 1'b1; v = exp_q2.pop_front(); end
    endcase
  endtask

  // Reference product: sign-extend both operands, keep the low 32 bits.
  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] ea, eb;
    ea = {{16{a[15]}}, a};
    eb = {{16{b[15]}}, b};
    return ea * eb;
  endfunction

  // Monitor: every modvalid must match the oldest expectation, on time.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (w_mv[k] === 1'b1) begin
        bit          ok;
        logic [95:0] v;
        pop_exp(k, ok, v);
        chk($sformatf("expected_modvalid_%0d", k), {31'd0, ok}, 32'd1);
        if (ok) begin
          chk($sformatf("latency_%0d", k), cyc, v[95:64]);
          chk($sformatf("sinmod_%0d", k), w_sinmod[k], v[63:32]);
          chk($sformatf("cosmod_%0d", k), w_cosmod[k], v[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Drives one newdata cycle on instance k; pushes an expectation if the
  // sample should be accepted.
  task automatic send(input int k, input logic [15:0] a, input logic [15:0] s,
                      input logic [15:0] c, input bit acc, input bit clr);
    @(posedge clk); #1;
    nd[k] = 1'b1; adc_in[k] = a; sin_in[k] = s; cos_in[k] = c; clr_ov[k] = clr;
    if (acc) push_exp(k, {cyc + 32'(3 + lat_of(k)), ref_mul(s, a), ref_mul(c, a)});
    @(posedge clk); #1;
    nd[k] = 1'b0; clr_ov[k] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int k = 0; k < 3; k++) begin
      nd[k] = 1'b0; adc_in[k] = '0; sin_in[k] = '0; cos_in[k] = '0; clr_ov[k] = 1'b0;
    end
    rst = 1'b1;
    idle(3);
    rst = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_m_a", 32'(w_ma[1]), 0);
    chk("rst_m_b", 32'(w_mb[1]), 0);
    chk("rst_sinmod", w_sinmod[1], 0);
    chk("rst_cosmod", w_cosmod[1], 0);
    chk("rst_modvalid", {31'd0, w_mv[1]}, 0);
    chk("rst_busy", {31'd0, w_busy[1]}, 0);
    chk("rst_overrun", {31'd0, w_ovr[1]}, 0);
    chk("rst_state", {29'd0, w_state[1]}, {29'd0, ST_IDLE});

    // Basic sample, with operand issue order checked
    send(1, 16'sd1000, 16'sd16384, -16'sd16384, 1'b1, 1'b0);
    @(negedge clk);
    chk("c1_busy", {31'd0, w_busy[1]}, 1);
    chk("c1_m_a", 32'(w_ma[1]), 16384);
    chk("c1_m_b", 32'(w_mb[1]), 1000);
    @(negedge clk);
    chk("c2_m_a", 32'(w_ma[1]), -16384);
    chk("c2_m_b", 32'(w_mb[1]), 1000);
    @(negedge clk);
    chk("c3_m_a", 32'(w_ma[1]), 0);
    idle(6);
    chk("basic_sinmod", w_sinmod[1], 16384000);
    chk("basic_cosmod", w_cosmod[1], -16384000);

    // Extremes, then outputs hold while idle
    send(1, -16'sd32768, -16'sd32768, 16'sd32767, 1'b1, 1'b0);
    idle(6);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("hold_sinmod", w_sinmod[1], 32'sd1073741824);
      chk("hold_cosmod", w_cosmod[1], -32'sd1073709056);
    end

    // Back-to-back: second sample lands in the DONE cycle
    send(1, 16'sd123, -16'sd7, 16'sd300, 1'b1, 1'b0);
    idle(3);
    send(1, -16'sd2000, 16'sd4000, -16'sd5, 1'b1, 1'b0);
    idle(8);
    @(negedge clk);
    chk("b2b_overrun", {31'd0, w_ovr[1]}, 0);

    // Overrun: second newdata at cycle 2 is dropped
    send(1, 16'sd11, 16'sd22, 16'sd33, 1'b1, 1'b0);
    send(1, 16'sd99, 16'sd99, 16'sd99, 1'b0, 1'b0);
    @(negedge clk);
    chk("ovr_set", {31'd0, w_ovr[1]}, 1);
    idle(8);
    // Clear coincident with a fresh overrun: set wins
    send(1, 16'sd5, -16'sd6, 16'sd7, 1'b1, 1'b0);
    send(1, 16'sd1, 16'sd1, 16'sd1, 1'b0, 1'b1);
    @(negedge clk);
    chk("ovr_set_wins", {31'd0, w_ovr[1]}, 1);
    idle(8);
    clr_ov[1] = 1'b1;
    idle(1);
    clr_ov[1] = 1'b0;
    @(negedge clk);
    chk("ovr_cleared", {31'd0, w_ovr[1]}, 0);

    // Reset mid-operation: no modvalid, outputs cleared
    send(1, 16'sd300, 16'sd400, 16'sd500, 1'b1, 1'b0);
    idle(1);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q1.delete();
    idle(1);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("mid_rst_modvalid", {31'd0, w_mv[1]}, 0);
      chk("mid_rst_busy", {31'd0, w_busy[1]}, 0);
    end
    chk("mid_rst_sinmod", w_sinmod[1], 0);
    chk("mid_rst_cosmod", w_cosmod[1], 0);
    chk("mid_rst_m_a", 32'(w_ma[1]), 0);
    send(1, -16'sd77, 16'sd1234, -16'sd4321, 1'b1, 1'b0);
    idle(8);

    // Random sweep over all three latencies
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < 3; k++) begin
        send(k, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
             16'($urandom_range(0, 65535)), 1'b1, 1'b0);
      end
      idle(10);
    end

    // Every expectation must have been consumed
    idle(20);
    chk("q0_drained", exp_q0.size(), 0);
    chk("q1_drained", exp_q1.size(), 0);
    chk("q2_drained", exp_q2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
